ahb_bridge_arbiter: RTL
=======================

AHB_BRIDGE_ARBITER -- requirements
Module: ahb_bridge_arbiter

Interface
REQ-001 Parameters SHALL be DATA_WIDTH, default 32, data bus width; and ADDR_WIDTH, default 32, address width.
REQ-002 Clock SHALL be i_clk  input  1  single clock; all logic is rising-edge.
REQ-003 Reset SHALL be i_rstn  input  1  asynchronous, active-low.
REQ-004 Per-master ports SHALL be i_mN_htrans, N=0,1  input  1  transfer request.
REQ-005 Per-master ports SHALL be i_mN_hsize  input  3  transfer size.
REQ-006 Per-master ports SHALL be i_mN_hwrite  input  1  1 = write.
REQ-007 Per-master ports SHALL be i_mN_haddr  input  ADDR_WIDTH  address.
REQ-008 Per-master ports SHALL be i_mN_hwdata  input  DATA_WIDTH  write data.
REQ-009 Per-master ports SHALL be o_mN_hready  output  1  transfer done / not stalled.
REQ-010 Per-master ports SHALL be o_mN_hresp  output  1  error response.
REQ-011 Per-master ports SHALL be o_mN_hrdata  output  DATA_WIDTH  read data.
REQ-012 Bridge-side ports SHALL be o_htrans  output  1; o_hsize  output  3; o_hwrite  output  1; o_haddr  output  ADDR_WIDTH; o_hwdata  output  DATA_WIDTH; o_hselx  output  1.
REQ-013 Bridge-side returns SHALL be i_hreadyout  input  1; i_hresp  input  1; i_hrdata  input  DATA_WIDTH.
REQ-014 Sleep ports SHALL be i_sleep_req  input  1  request quiesce; o_sleep_ack  output  1  bridge quiesced.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, DATA, SLEEP; one transfer outstanding at a time (no address/data overlap).
REQ-016 Masters SHALL hold htrans/hsize/hwrite/haddr/hwdata stable while their o_mN_hready is 0.
REQ-017 In IDLE with i_sleep_req=1, the FSM SHALL go to SLEEP; sleep has priority over pending requests.
REQ-018 In IDLE, no sleep and any htrans=1: grant via round-robin and go to ADDR; with both requesting, grant the master not granted last; on a single request, grant it.
REQ-019 In ADDR: o_htrans=1, o_hselx=1, and o_hsize/o_hwrite/o_haddr SHALL equal the owner's; on an edge with i_hreadyout=1 go to DATA.
REQ-020 In DATA: o_htrans=0, o_hwdata = owner's hwdata; on an edge with i_hreadyout=1 go to IDLE, update the last-granted pointer.
REQ-021 o_mN_hready SHALL be 1 in the DATA cycle where i_hreadyout=1 for the owner.
REQ-022 o_mN_hready SHALL be 0 while mN has htrans=1 and is not completing.
REQ-023 o_mN_hready SHALL be 1 otherwise.
REQ-024 o_mN_hrdata/o_mN_hresp SHALL mirror i_hrdata/i_hresp for the owner in DATA, 0 for the non-owner.
REQ-025 i_hresp=1 SHALL end the transfer like a normal completion; no retry.
REQ-026 i_sleep_req rising during ADDR/DATA SHALL be serviced after the current transfer completes; the transfer is never aborted.
REQ-027 In SLEEP, o_sleep_ack=1; o_htrans=0; o_hselx=0; both o_mN_hready=0 for requesting masters.
REQ-028 In SLEEP, i_sleep_req=0 SHALL return the FSM to IDLE with o_sleep_ack=0 on the next edge.
REQ-029 A master dropping htrans SHALL cause no grant in IDLE; drops in ADDR/DATA SHALL be ignored.
REQ-030 Bus outputs in IDLE SHALL be 0, except o_mN_hready per REQ-023.

Reset
REQ-031 On i_rstn=0: state=IDLE, last-granted=M1 (M0 wins first tie), o_sleep_ack=0, all bridge outputs 0, o_mN_hready=1, o_mN_hresp=0, o_mN_hrdata=0.
REQ-032 Reset asserted mid-transfer SHALL abort it immediately, without completing.

Structure
REQ-033 The FSM state encoding and the master count (2) SHALL live in shared package ahb_bridge_pkg.
REQ-034 Round-robin selection SHALL be sub-module rr_arbiter_2 (req[1:0], last, grant[1:0]), combinational.

Verification
REQ-035 Reset, M0 write haddr=0xA, hwdata=0xAAAA, i_hreadyout=1 -> o_haddr=0xA for 1 cycle, then o_hwdata=0xAAAA; o_m0_hready=1 on cycle 2.
REQ-036 M0 and M1 request same cycle after reset -> M0 served first, then M1; repeat -> M1 then M0.
REQ-037 M1 read 0xD, i_hreadyout=0 for 3 DATA cycles, then i_hrdata=0xDDDD -> o_m1_hready=0 for 3 cycles, then 1 with o_m1_hrdata=0xDDDD.
REQ-038 i_sleep_req=1 during M0 DATA -> transfer completes; next cycle o_sleep_ack=1; M1 request held stalled until i_sleep_req=0.
REQ-039 i_hresp=1 on M0 transfer -> o_m0_hresp=1 in completion cycle; FSM returns to IDLE.
REQ-040 i_rstn=0 during ADDR -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ahb_bridge_pkg.sv
// ahb_bridge_pkg: shared FSM encoding and master count for the bridge arbiter
package ahb_bridge_pkg;
  localparam int NUM_MASTERS = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_SLEEP} state_t;
endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// ahb_bridge_arbiter_if: two AHB-lite masters, the bridge-side bus and the sleep handshake
interface ahb_bridge_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_m0_htrans, i_m1_htrans;
  logic [2:0]            i_m0_hsize, i_m1_hsize;
  logic                  i_m0_hwrite, i_m1_hwrite;
  logic [ADDR_WIDTH-1:0] i_m0_haddr, i_m1_haddr;
  logic [DATA_WIDTH-1:0] i_m0_hwdata, i_m1_hwdata;
  logic                  o_m0_hready, o_m1_hready;
  logic                  o_m0_hresp, o_m1_hresp;
  logic [DATA_WIDTH-1:0] o_m0_hrdata, o_m1_hrdata;
  logic                  o_htrans, o_hwrite, o_hselx;
  logic [2:0]            o_hsize;
  logic [ADDR_WIDTH-1:0] o_haddr;
  logic [DATA_WIDTH-1:0] o_hwdata;
  logic                  i_hreadyout, i_hresp;
  logic [DATA_WIDTH-1:0] i_hrdata;
  logic                  i_sleep_req, o_sleep_ack;
  modport slave (
    input  i_m0_htrans, i_m1_htrans, i_m0_hsize, i_m1_hsize, i_m0_hwrite, i_m1_hwrite,
           i_m0_haddr, i_m1_haddr, i_m0_hwdata, i_m1_hwdata, i_hreadyout, i_hresp, i_hrdata, i_sleep_req,
    output o_m0_hready, o_m1_hready, o_m0_hresp, o_m1_hresp, o_m0_hrdata, o_m1_hrdata,
           o_htrans, o_hwrite, o_hselx, o_hsize, o_haddr, o_hwdata, o_sleep_ack
  );
  modport master (
    output i_m0_htrans, i_m1_htrans, i_m0_hsize, i_m1_hsize, i_m0_hwrite, i_m1_hwrite,
           i_m0_haddr, i_m1_haddr, i_m0_hwdata, i_m1_hwdata, i_hreadyout, i_hresp, i_hrdata, i_sleep_req,
    input  o_m0_hready, o_m1_hready, o_m0_hresp, o_m1_hresp, o_m0_hrdata, o_m1_hrdata,
           o_htrans, o_hwrite, o_hselx, o_hsize, o_haddr, o_hwdata, o_sleep_ack
  );
endinterface

// File: rtl/ahb_bridge_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick; on a tie the master not granted last wins
module rr_arbiter_2
  import ahb_bridge_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   last,
  output logic [NUM_MASTERS-1:0] grant
);
  assign grant = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
endmodule

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: serialises two AHB-lite masters onto one bridge port, one transfer at a time,
// with a sleep handshake that only takes effect between transfers.
module ahb_bridge_arbiter
  import ahb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic i_clk,
  input logic i_rstn,
  ahb_bridge_arbiter_if.slave bus
);
  state_t                 r_state, w_next;
  logic                   r_owner, r_last;
  logic                   w_in_addr, w_in_data, w_start, w_hwrite;
  logic [2:0]             w_hsize;
  logic [ADDR_WIDTH-1:0]  w_haddr;
  logic [DATA_WIDTH-1:0]  w_hwdata;
  logic [NUM_MASTERS-1:0] w_req, w_grant, w_busy, w_own_data, w_done;

  assign w_req   = {bus.i_m1_htrans, bus.i_m0_htrans};
  assign w_start = (r_state == ST_IDLE) && !bus.i_sleep_req && |w_req;

  rr_arbiter_2 u_rr (.req(w_req), .last(r_last), .grant(w_grant));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_start) r_owner <= w_grant[1];
      if (w_in_data && bus.i_hreadyout) r_last <= r_owner;
    end
  end

  // a completing transfer with sleep pending goes straight to SLEEP
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = bus.i_sleep_req ? ST_SLEEP : (|w_req ? ST_ADDR : ST_IDLE);
      ST_ADDR:  w_next = bus.i_hreadyout ? ST_DATA : ST_ADDR;
      ST_DATA:  w_next = !bus.i_hreadyout ? ST_DATA : (bus.i_sleep_req ? ST_SLEEP : ST_IDLE);
      ST_SLEEP: w_next = bus.i_sleep_req ? ST_SLEEP : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // owner stays stalled for its whole transfer even if it drops htrans meanwhile
  always_comb begin
    w_in_addr       = r_state == ST_ADDR;
    w_in_data       = r_state == ST_DATA;
    w_haddr         = r_owner ? bus.i_m1_haddr : bus.i_m0_haddr;
    w_hwdata        = r_owner ? bus.i_m1_hwdata : bus.i_m0_hwdata;
    w_hsize         = r_owner ? bus.i_m1_hsize : bus.i_m0_hsize;
    w_hwrite        = r_owner ? bus.i_m1_hwrite : bus.i_m0_hwrite;
    w_busy          = (w_in_addr || w_in_data) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    w_own_data      = w_in_data ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    w_done          = bus.i_hreadyout ? w_own_data : 2'b00;
    bus.o_htrans    = w_in_addr;
    bus.o_hselx     = w_in_addr;
    bus.o_hsize     = w_in_addr ? w_hsize : '0;
    bus.o_hwrite    = w_in_addr && w_hwrite;
    bus.o_haddr     = w_in_addr ? w_haddr : '0;
    bus.o_hwdata    = w_in_data ? w_hwdata : '0;
    bus.o_m0_hready = !i_rstn || w_done[0] || !(w_req[0] || w_busy[0]);
    bus.o_m1_hready = !i_rstn || w_done[1] || !(w_req[1] || w_busy[1]);
    bus.o_m0_hrdata = w_own_data[0] ? bus.i_hrdata : '0;
    bus.o_m1_hrdata = w_own_data[1] ? bus.i_hrdata : '0;
    bus.o_m0_hresp  = w_own_data[0] && bus.i_hresp;
    bus.o_m1_hresp  = w_own_data[1] && bus.i_hresp;
    bus.o_sleep_ack = r_state == ST_SLEEP;
  end
endmodule
